// File: rtl/octree_mem_arbiter.sv
// octree_mem_arbiter: per-cycle round-robin arbiter in front of one single-port
// SRAM macro, with lock-held bursts, host override and tagged read return.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   ext_en/req/we/addr/wdata        host override path (owns SRAM while ext_en=1)
//   ext_rdata, ext_rvalid           host read return
//   port_req/we/lock/addr/wdata     packed per-engine request bundle
//   port_gnt                        one-hot combinational grant
//   port_rvalid, port_rdata         one-hot engine read return, shared data
//   sram_req/we/addr/wdata/rdata    SRAM macro interface
//   stall_clr, stall_cnt            saturating count of cycles with a waiting engine
module octree_mem_arbiter #(
    parameter int unsigned NUM_PORTS       = 4,
    parameter int unsigned ADDR_WIDTH      = 10,
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned RD_LATENCY      = 1,
    parameter int unsigned STALL_CNT_WIDTH = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            ext_en,
    input  logic                            ext_req,
    input  logic                            ext_we,
    input  logic [ADDR_WIDTH-1:0]           ext_addr,
    input  logic [DATA_WIDTH-1:0]           ext_wdata,
    output logic [DATA_WIDTH-1:0]           ext_rdata,
    output logic                            ext_rvalid,
    input  logic [NUM_PORTS-1:0]            port_req,
    input  logic [NUM_PORTS-1:0]            port_we,
    input  logic [NUM_PORTS-1:0]            port_lock,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] port_wdata,
    output logic [NUM_PORTS-1:0]            port_gnt,
    output logic [NUM_PORTS-1:0]            port_rvalid,
    output logic [DATA_WIDTH-1:0]           port_rdata,
    output logic                            sram_req,
    output logic                            sram_we,
    output logic [ADDR_WIDTH-1:0]           sram_addr,
    output logic [DATA_WIDTH-1:0]           sram_wdata,
    input  logic [DATA_WIDTH-1:0]           sram_rdata,
    input  logic                            stall_clr,
    output logic [STALL_CNT_WIDTH-1:0]      stall_cnt
);

    localparam int unsigned PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned LAST_PORT = NUM_PORTS - 1;

    typedef struct packed {
        logic          valid;
        logic          is_ext;
        logic [PW-1:0] id;
    } ret_tag_t;

    localparam int unsigned PIPE_W = RD_LATENCY * $bits(ret_tag_t);

    logic [PW-1:0]                  rr_ptr, rr_ptr_nxt;
    logic [PW-1:0]                  owner, owner_nxt;
    logic                           owner_valid, owner_valid_nxt;
    ret_tag_t [RD_LATENCY-1:0]      pipe, pipe_nxt;
    ret_tag_t                       head, exit_tag;
    logic [STALL_CNT_WIDTH-1:0]     stall_cnt_nxt;
    logic [NUM_PORTS-1:0]           eligible;
    logic                           gnt_valid;
    logic [PW-1:0]                  gnt_idx;

    function automatic logic [PW-1:0] next_port(input logic [PW-1:0] p);
        return (32'(p) == LAST_PORT) ? '0 : PW'(32'(p) + 32'd1);
    endfunction

    // A valid owner masks everyone else out of arbitration.
    always_comb begin
        eligible = port_req;
        if (owner_valid) eligible = port_req & (NUM_PORTS'(1) << owner);
    end

    // First eligible port scanning upward from rr_ptr, modulo NUM_PORTS.
    always_comb begin
        int unsigned j;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        j         = 0;
        if (!ext_en) begin
            for (int unsigned k = 0; k < NUM_PORTS; k++) begin
                j = 32'(rr_ptr) + k;
                if (j >= NUM_PORTS) j = j - NUM_PORTS;
                if (!gnt_valid && eligible[PW'(j)]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = PW'(j);
                end
            end
        end
    end

    // SRAM request mux: host path or granted engine.
    always_comb begin
        port_gnt   = '0;
        sram_req   = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (ext_en) begin
            sram_req   = ext_req;
            sram_we    = ext_we;
            sram_addr  = ext_addr;
            sram_wdata = ext_wdata;
        end else begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                if (gnt_valid && gnt_idx == PW'(i)) begin
                    port_gnt[i] = 1'b1;
                    sram_req    = 1'b1;
                    sram_we     = port_we[i];
                    sram_addr   = port_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                    sram_wdata  = port_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Next-state: pointer/lock ownership, return-tag shift, stall counter.
    always_comb begin
        rr_ptr_nxt      = rr_ptr;
        owner_nxt       = owner;
        owner_valid_nxt = owner_valid;
        stall_cnt_nxt   = stall_cnt;

        head.valid  = sram_req & ~sram_we;
        head.is_ext = ext_en;
        head.id     = gnt_idx;
        // Shift toward the exit stage; the oldest tag falls off the top.
        pipe_nxt    = PIPE_W'({pipe, head});

        if (ext_en) begin
            owner_valid_nxt = 1'b0;
        end else if (owner_valid) begin
            // Owner is granted whenever it requests, so lock=0 or no request releases.
            if (!port_req[owner] || !port_lock[owner]) begin
                owner_valid_nxt = 1'b0;
                rr_ptr_nxt      = next_port(owner);
            end
        end else if (gnt_valid) begin
            if (port_lock[gnt_idx]) begin
                owner_valid_nxt = 1'b1;
                owner_nxt       = gnt_idx;
            end else begin
                rr_ptr_nxt = next_port(gnt_idx);
            end
        end

        if (stall_clr) begin
            stall_cnt_nxt = '0;
        end else if ((|(port_req & ~port_gnt)) && (stall_cnt != '1)) begin
            stall_cnt_nxt = stall_cnt + STALL_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr      <= '0;
            owner       <= '0;
            owner_valid <= 1'b0;
            pipe        <= '0;
            stall_cnt   <= '0;
        end else begin
            rr_ptr      <= rr_ptr_nxt;
            owner       <= owner_nxt;
            owner_valid <= owner_valid_nxt;
            pipe        <= pipe_nxt;
            stall_cnt   <= stall_cnt_nxt;
        end
    end

    // Route the exiting tag; the macro's data lines up with it by construction.
    always_comb begin
        exit_tag    = pipe[RD_LATENCY-1];
        port_rvalid = '0;
        port_rdata  = '0;
        ext_rvalid  = 1'b0;
        ext_rdata   = '0;
        if (exit_tag.valid) begin
            if (exit_tag.is_ext) begin
                ext_rvalid = 1'b1;
                ext_rdata  = sram_rdata;
            end else begin
                port_rvalid[exit_tag.id] = 1'b1;
                port_rdata               = sram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_octree_mem_arbiter.sv
// Bench for octree_mem_arbiter: directed scenarios plus a random phase, all
// checked each cycle against a transaction-level model (grant choice, memory
// contents, expected-return queue, stall count).
module tb_octree_mem_arbiter;

    localparam int NP   = 4;
    localparam int AW   = 6;
    localparam int DW   = 64;
    localparam int LAT  = 2;
    localparam int SW   = 4;
    localparam int DEPTH = 1 << AW;
    localparam int SMAX  = (1 << SW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             ext_en, ext_req, ext_we;
    logic [AW-1:0]    ext_addr;
    logic [DW-1:0]    ext_wdata, ext_rdata;
    logic             ext_rvalid;
    logic [NP-1:0]    port_req, port_we, port_lock, port_gnt, port_rvalid;
    logic [NP*AW-1:0] port_addr;
    logic [NP*DW-1:0] port_wdata;
    logic [DW-1:0]    port_rdata;
    logic             sram_req, sram_we;
    logic [AW-1:0]    sram_addr;
    logic [DW-1:0]    sram_wdata, sram_rdata;
    logic             stall_clr;
    logic [SW-1:0]    stall_cnt;

    octree_mem_arbiter #(
        .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .RD_LATENCY(LAT), .STALL_CNT_WIDTH(SW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ext_en(ext_en), .ext_req(ext_req), .ext_we(ext_we),
        .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid),
        .port_req(port_req), .port_we(port_we), .port_lock(port_lock),
        .port_addr(port_addr), .port_wdata(port_wdata),
        .port_gnt(port_gnt), .port_rvalid(port_rvalid), .port_rdata(port_rdata),
        .sram_req(sram_req), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .stall_clr(stall_clr), .stall_cnt(stall_cnt)
    );

    // SRAM macro with LAT-cycle read latency.
    logic [DW-1:0] mem  [DEPTH];
    logic [DW-1:0] rd_q [LAT];
    always @(posedge clk) begin
        if (sram_req && sram_we) mem[sram_addr] <= sram_wdata;
        rd_q[0] <= (sram_req && !sram_we) ? mem[sram_addr] : '0;
        for (int i = 1; i < LAT; i++) rd_q[i] <= rd_q[i-1];
    end
    assign sram_rdata = rd_q[LAT-1];

    // Reference model state.
    typedef struct {
        int          due;
        bit          is_ext;
        int          port;
        logic [DW-1:0] data;
    } ret_t;

    ret_t          q[$];
    logic [DW-1:0] mm [DEPTH];
    int            m_rr, m_owner, m_stall, cyc;
    int            checks = 0;
    int            failures = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int model_grant();
        if (ext_en) return -1;
        for (int k = 0; k < NP; k++) begin
            int p;
            p = (m_rr + k) % NP;
            if (port_req[p] && (m_owner < 0 || m_owner == p)) return p;
        end
        return -1;
    endfunction

    // Check this cycle's outputs, advance the model, move to the next cycle.
    task automatic step();
        int            g;
        ret_t          r;
        logic [NP-1:0] eg, epv;
        logic          er, ew, ev;
        logic [AW-1:0] ea;
        logic [DW-1:0] ewd, epd, eed, rdat;
        #1;
        g  = model_grant();
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        er = 1'b0; ew = 1'b0; ea = '0; ewd = '0;
        if (ext_en) begin
            er = ext_req; ew = ext_we; ea = ext_addr; ewd = ext_wdata;
        end else if (g >= 0) begin
            er = 1'b1; ew = port_we[g];
            ea = port_addr[g*AW +: AW]; ewd = port_wdata[g*DW +: DW];
        end
        epv = '0; epd = '0; ev = 1'b0; eed = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
            r = q.pop_front();
            if (r.is_ext) begin ev = 1'b1; eed = r.data; end
            else begin epv[r.port] = 1'b1; epd = r.data; end
        end

        chk("port_gnt",    DW'(port_gnt),    DW'(eg));
        chk("sram_req",    DW'(sram_req),    DW'(er));
        chk("sram_we",     DW'(sram_we),     DW'(ew));
        if (er) begin
            chk("sram_addr",  DW'(sram_addr), DW'(ea));
            chk("sram_wdata", sram_wdata,     ewd);
        end
        chk("port_rvalid", DW'(port_rvalid), DW'(epv));
        chk("port_rdata",  port_rdata,       epd);
        chk("ext_rvalid",  DW'(ext_rvalid),  DW'(ev));
        chk("ext_rdata",   ext_rdata,        eed);
        chk("stall_cnt",   DW'(stall_cnt),   DW'(m_stall));

        rdat = '0;
        if (er) begin
            if (ew) mm[ea] = ewd;
            else    rdat = mm[ea];
        end
        if (!rst_n) begin
            m_rr = 0; m_owner = -1; m_stall = 0;
            q.delete();
        end else begin
            if (er && !ew) begin
                r.due = cyc + LAT; r.is_ext = ext_en; r.port = g; r.data = rdat;
                q.push_back(r);
            end
            if (stall_clr) m_stall = 0;
            else if (((port_req & ~eg) != '0) && m_stall < SMAX) m_stall++;
            if (ext_en) begin
                m_owner = -1;
            end else if (m_owner >= 0) begin
                if (!port_req[m_owner] || !port_lock[m_owner]) begin
                    m_rr = (m_owner + 1) % NP;
                    m_owner = -1;
                end
            end else if (g >= 0) begin
                if (port_lock[g]) m_owner = g;
                else              m_rr = (g + 1) % NP;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle();
        rst_n = 1'b1; ext_en = 1'b0; ext_req = 1'b0; ext_we = 1'b0;
        port_req = '0; port_we = '0; port_lock = '0; stall_clr = 1'b0;
    endtask

    task automatic rand_ports();
        for (int i = 0; i < NP; i++) begin
            port_addr[i*AW +: AW]  = AW'($urandom);
            port_wdata[i*DW +: DW] = {$urandom, $urandom};
        end
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        ext_addr = '0; ext_wdata = '0;
        rand_ports();
        @(negedge clk);
        m_rr = 0; m_owner = -1; m_stall = 0; cyc = 0;

        // Reset state held for one more checked cycle.
        step();
        idle();

        // Preload every word through the host path.
        for (int a = 0; a < DEPTH; a++) begin
            ext_en = 1'b1; ext_req = 1'b1; ext_we = 1'b1;
            ext_addr = AW'(a); ext_wdata = {$urandom, $urandom};
            step();
        end
        idle();
        step();

        // Round-robin: all four ports hold reads for 8 cycles.
        port_req = 4'hF;
        for (int c = 0; c < 8; c++) begin rand_ports(); step(); end
        idle();
        for (int c = 0; c < LAT + 1; c++) step();

        // Move the pointer to port 2, then a locked burst from port 2 vs port 0.
        port_req = 4'b0010; rand_ports(); step();
        for (int c = 0; c < 3; c++) begin
            port_req = 4'b0101;
            port_lock = (c < 2) ? 4'b0100 : 4'b0000;
            port_addr[2*AW +: AW] = AW'(5 + c);
            step();
        end
        port_lock = '0; port_req = 4'b0001; step();
        idle();
        for (int c = 0; c < LAT + 1; c++) step();

        // Host override behind an in-flight engine read.
        port_req = 4'b0010; port_addr[1*AW +: AW] = AW'(3); step();
        port_req = 4'b0000;
        ext_en = 1'b1; ext_req = 1'b1; ext_we = 1'b1;
        ext_addr = AW'(3); ext_wdata = 64'hDEAD; step();
        port_req = 4'b1000;
        ext_we = 1'b0; step();
        ext_req = 1'b0; step();
        idle();
        for (int c = 0; c < LAT + 1; c++) step();

        // Stall saturation and clear.
        port_req = 4'b0011;
        for (int c = 0; c < 20; c++) begin rand_ports(); step(); end
        stall_clr = 1'b1; step();
        stall_clr = 1'b0; step();
        idle();
        for (int c = 0; c < LAT + 1; c++) step();

        // Mid-operation reset with a lock owner and a read in flight.
        port_req = 4'b0010; port_lock = 4'b0010; rand_ports(); step();
        idle(); rst_n = 1'b0; step();
        idle();
        for (int c = 0; c < LAT + 1; c++) step();
        port_req = 4'b1010; port_lock = '0; step();
        idle();
        for (int c = 0; c < LAT + 1; c++) step();

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            ext_en    = ($urandom_range(0, 7) == 0);
            ext_req   = 1'($urandom);
            ext_we    = ($urandom_range(0, 2) == 0);
            ext_addr  = AW'($urandom);
            ext_wdata = {$urandom, $urandom};
            port_req  = NP'($urandom);
            port_we   = NP'($urandom) & NP'($urandom);
            port_lock = NP'($urandom) & NP'($urandom);
            stall_clr = ($urandom_range(0, 19) == 0);
            rand_ports();
            step();
        end
        idle();
        for (int c = 0; c < LAT + 2; c++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
